// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR/XOR popcount accumulator: word modes and frame FSM states.
package xnor_pkg;

  localparam logic MODE_XNOR = 1'b0;
  localparam logic MODE_XOR  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/xnor_popcount_acc_if.sv
// Operand-pair input stream and frame-result output stream of the popcount accumulator.
interface xnor_popcount_acc_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_words;
  logic             out_sat;

  modport master (
    output in_valid, in_a, in_b, in_last, mode, out_ready,
    input  in_ready, out_valid, out_sum, out_words, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, mode, out_ready,
    output in_ready, out_valid, out_sum, out_words, out_sat
  );
endinterface

// File: rtl/xnor_popcount.sv
// Combinational per-word match/difference counter: popcount of XNOR (mode 0) or XOR (mode 1).
module xnor_popcount
  import xnor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PC_W  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             mode,
  output logic [PC_W-1:0]  pc
);
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] bits_s;

  // Select matching or differing bits and count them
  always_comb begin
    diff_s = in_a ^ in_b;
    bits_s = (mode == MODE_XNOR) ? ~diff_s : diff_s;
    pc     = {PC_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      pc = pc + PC_W'(bits_s[i]);
    end
  end
endmodule

// File: rtl/xnor_popcount_acc.sv
// Frame accumulator: sums per-word popcounts until in_last, then publishes one registered
// result (sum, word count, saturation flag) on a valid/ready output.
module xnor_popcount_acc
  import xnor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  xnor_popcount_acc_if.slave bus
);
  localparam int PC_W = $clog2(WIDTH + 1);

  state_t           state_r, state_nxt_s;
  logic [PC_W-1:0]  pc_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s, out_sum_r;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, out_words_r;
  logic             sat_r, sat_nxt_s, out_sat_r, out_valid_r;
  logic             in_ready_s, accept_s, publish_s;

  xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
    .in_a (bus.in_a),
    .in_b (bus.in_b),
    .mode (bus.mode),
    .pc   (pc_s)
  );

  // A held result only blocks input when downstream is not taking it this cycle
  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign sum_s      = {1'b0, acc_r} + (ACC_W + 1)'(pc_s);

  // Next frame state: start a frame from IDLE, extend it with saturating arithmetic in ACC
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    sat_nxt_s   = sat_r;
    publish_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ACC: begin
          acc_nxt_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];
          sat_nxt_s = sat_r | sum_s[ACC_W];
          cnt_nxt_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        end
        default: begin
          acc_nxt_s = ACC_W'(pc_s);
          cnt_nxt_s = CNT_W'(1);
          sat_nxt_s = 1'b0;
        end
      endcase
      if (bus.in_last) begin
        publish_s   = 1'b1;
        state_nxt_s = IDLE;
      end else begin
        state_nxt_s = ACC;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= {ACC_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sat_r   <= sat_nxt_s;
    end
  end

  // Result register: a publish may coincide with the transfer of the previous result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_words_r <= {CNT_W{1'b0}};
      out_sat_r   <= 1'b0;
    end else if (publish_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= acc_nxt_s;
      out_words_r <= cnt_nxt_s;
      out_sat_r   <= sat_nxt_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_words = out_words_r;
  assign bus.out_sat   = out_sat_r;
endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Self-checking bench: two accumulators (ACC_W=16 and ACC_W=6) fed the same stream and
// compared against a frame-level arithmetic model.
module tb_xnor_popcount_acc;
  import xnor_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid_s = 1'b0, in_last_s = 1'b0, mode_s = 1'b0, out_ready_s = 1'b1;
  logic [7:0] in_a_s = 8'h00, in_b_s = 8'h00;

  xnor_popcount_acc_if #(.WIDTH(8), .ACC_W(16), .CNT_W(8)) if16 ();
  xnor_popcount_acc_if #(.WIDTH(8), .ACC_W(6),  .CNT_W(8)) if6 ();

  assign if16.in_valid = in_valid_s;  assign if6.in_valid = in_valid_s;
  assign if16.in_a = in_a_s;          assign if6.in_a = in_a_s;
  assign if16.in_b = in_b_s;          assign if6.in_b = in_b_s;
  assign if16.in_last = in_last_s;    assign if6.in_last = in_last_s;
  assign if16.mode = mode_s;          assign if6.mode = mode_s;
  assign if16.out_ready = out_ready_s; assign if6.out_ready = out_ready_s;

  xnor_popcount_acc #(.WIDTH(8), .ACC_W(16), .CNT_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  xnor_popcount_acc #(.WIDTH(8), .ACC_W(6),  .CNT_W(8)) dut6  (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

  // {out_valid, out_sum, out_words, out_sat}
  wire [25:0] obs16 = {if16.out_valid, if16.out_sum, if16.out_words, if16.out_sat};
  wire [15:0] obs6  = {if6.out_valid, if6.out_sum, if6.out_words, if6.out_sat};

  int errors = 0;
  int checks = 0;
  int m_total = 0;
  int m_n = 0;

  // Frame model: plain integer total and word count, clipped to the result widths
  function automatic logic [25:0] exp16();
    int s, w;
    s = (m_total > 65535) ? 65535 : m_total;
    w = (m_n > 255) ? 255 : m_n;
    return {1'b1, 16'(s), 8'(w), (m_total > 65535)};
  endfunction

  function automatic logic [15:0] exp6();
    int s, w;
    s = (m_total > 63) ? 63 : m_total;
    w = (m_n > 255) ? 255 : m_n;
    return {1'b1, 6'(s), 8'(w), (m_total > 63)};
  endfunction

  // Offer one word at a negedge, wait (bounded) for acceptance, return at the following negedge
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic m, input logic last);
    logic [7:0] x, y;
    int k;
    in_a_s = a; in_b_s = b; mode_s = m; in_last_s = last; in_valid_s = 1'b1;
    #1;
    k = 0;
    while (!if16.in_ready && k < 50) begin
      @(posedge clk); @(negedge clk); #1;
      k++;
    end
    if (!if16.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got %0b want 1 within 50 cycles", if16.in_ready);
    end
    checks++;
    @(posedge clk);
    x = a ^ b;
    y = ~x;
    m_total += (m == MODE_XOR) ? $countones(x) : $countones(y);
    m_n++;
    @(negedge clk);
    in_valid_s = 1'b0;
    in_last_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({if16.in_ready, obs16} !== {1'b1, 26'd0} || {if6.in_ready, obs6} !== {1'b1, 16'd0}) begin
      errors++;
      $display("FAIL reset: got rdy=%0b obs16=%h obs6=%h want rdy=1 obs=0", if16.in_ready, obs16, obs6);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    out_ready_s = 1'b0;
    m_total = 0; m_n = 0;
    send_word(8'hA5, 8'hA5, MODE_XNOR, 1'b1);
    checks++;
    if (obs16 !== {1'b1, 16'd8, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_word: got %h want %h", obs16, {1'b1, 16'd8, 8'd1, 1'b0});
    end
    out_ready_s = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid got %0b want 0", if16.out_valid);
    end
  endtask

  task automatic test_three_word();
    out_ready_s = 1'b0;
    send_word(8'hFF, 8'h00, MODE_XOR, 1'b0);
    checks++;
    if (if16.out_valid !== 1'b0) begin
      errors++; $display("FAIL three_w1: out_valid got %0b want 0", if16.out_valid);
    end
    send_word(8'hF0, 8'h0F, MODE_XOR, 1'b0);
    checks++;
    if (if16.out_valid !== 1'b0) begin
      errors++; $display("FAIL three_w2: out_valid got %0b want 0", if16.out_valid);
    end
    send_word(8'hAA, 8'hAA, MODE_XOR, 1'b1);
    checks++;
    if (obs16 !== {1'b1, 16'd16, 8'd3, 1'b0}) begin
      errors++; $display("FAIL three_result: got %h want %h", obs16, {1'b1, 16'd16, 8'd3, 1'b0});
    end
  endtask

  // Result from the three-word frame is held; an offered single-word frame must wait
  task automatic test_backpressure();
    in_a_s = 8'h0F; in_b_s = 8'hF0; mode_s = MODE_XOR; in_last_s = 1'b1; in_valid_s = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({if16.in_ready, obs16} !== {1'b0, 1'b1, 16'd16, 8'd3, 1'b0}) begin
        errors++;
        $display("FAIL hold_%0d: got rdy=%0b obs=%h want rdy=0 obs=%h", c, if16.in_ready, obs16,
                 {1'b1, 16'd16, 8'd3, 1'b0});
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready_s = 1'b1;
    #1;
    checks++;
    if (if16.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: in_ready got %0b want 1", if16.in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid_s = 1'b0; in_last_s = 1'b0;
    checks++;
    if (obs16 !== {1'b1, 16'd8, 8'd1, 1'b0}) begin
      errors++; $display("FAIL transfer_publish: got %h want %h", obs16, {1'b1, 16'd8, 8'd1, 1'b0});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: out_valid got %0b want 0", if16.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready_s = 1'b1;
    send_word(8'hFF, 8'hFF, MODE_XNOR, 1'b1);
    checks++;
    if (obs16 !== {1'b1, 16'd8, 8'd1, 1'b0}) begin
      errors++; $display("FAIL b2b_first: got %h want %h", obs16, {1'b1, 16'd8, 8'd1, 1'b0});
    end
    send_word(8'h00, 8'hFF, MODE_XNOR, 1'b1);
    checks++;
    if (obs16 !== {1'b1, 16'd0, 8'd1, 1'b0}) begin
      errors++; $display("FAIL b2b_second: got %h want %h", obs16, {1'b1, 16'd0, 8'd1, 1'b0});
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (if16.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: out_valid got %0b want 0", if16.out_valid);
    end
  endtask

  task automatic test_saturation();
    out_ready_s = 1'b1;
    for (int w = 0; w < 8; w++) send_word(8'hFF, 8'hFF, MODE_XNOR, (w == 7));
    checks++;
    if (obs6 !== {1'b1, 6'd63, 8'd8, 1'b1}) begin
      errors++; $display("FAIL sat6: got %h want %h", obs6, {1'b1, 6'd63, 8'd8, 1'b1});
    end
    checks++;
    if (obs16 !== {1'b1, 16'd64, 8'd8, 1'b0}) begin
      errors++; $display("FAIL sat16: got %h want %h", obs16, {1'b1, 16'd64, 8'd8, 1'b0});
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    out_ready_s = 1'b1;
    send_word(8'h12, 8'h34, MODE_XNOR, 1'b0);
    send_word(8'h56, 8'h78, MODE_XOR, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if16.in_ready, obs16} !== {1'b1, 26'd0}) begin
      errors++; $display("FAIL async_reset: got rdy=%0b obs=%h want rdy=1 obs=0", if16.in_ready, obs16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_word(8'h0F, 8'h0F, MODE_XNOR, 1'b1);
    checks++;
    if (obs16 !== {1'b1, 16'd8, 8'd1, 1'b0}) begin
      errors++; $display("FAIL after_reset: got %h want %h", obs16, {1'b1, 16'd8, 8'd1, 1'b0});
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random_frames();
    int len, hold;
    for (int f = 0; f < 20; f++) begin
      out_ready_s = 1'b0;
      m_total = 0; m_n = 0;
      len = $urandom_range(1, 6);
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 2) == 0) begin
          @(posedge clk); @(negedge clk);
        end
        send_word(8'($urandom), 8'($urandom), 1'($urandom), (w == len - 1));
      end
      checks++;
      if (obs16 !== exp16() || obs6 !== exp6()) begin
        errors++;
        $display("FAIL rand_frame_%0d: got %h/%h want %h/%h", f, obs16, obs6, exp16(), exp6());
      end
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        @(posedge clk); @(negedge clk);
      end
      checks++;
      if (obs16 !== exp16()) begin
        errors++; $display("FAIL rand_hold_%0d: got %h want %h", f, obs16, exp16());
      end
      out_ready_s = 1'b1;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_word_saturation();
    out_ready_s = 1'b0;
    m_total = 0; m_n = 0;
    for (int w = 0; w < 260; w++) send_word(8'($urandom), 8'($urandom), 1'($urandom), (w == 259));
    checks++;
    if (obs16 !== exp16() || obs6 !== exp6()) begin
      errors++;
      $display("FAIL word_sat: got %h/%h want %h/%h", obs16, obs6, exp16(), exp6());
    end
    out_ready_s = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_word();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    test_random_frames();
    test_word_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
